// File: rtl/guess_pkg.sv
// Shared definitions for the guess game: code geometry, lamp vector and playback states.
// Code columns are MSB-first: the top bit of each column mask is the first symbol.
package guess_pkg;

    localparam int MAX_LEN  = 7;
    localparam int NUM_COLS = 4;
    localparam int NUMA_W   = 4;
    localparam int POS_W    = 3;

    typedef enum logic [1:0] {IDLE, ON, GAP, DONE} pb_state_t;

    typedef logic [NUM_COLS:1]  lamp_t;
    typedef logic [MAX_LEN-1:0] code_t;
    typedef logic [POS_W-1:0]   pos_t;

    typedef struct packed {
        code_t a1;
        code_t a2;
        code_t a3;
        code_t a4;
        pos_t  len;
    } snap_t;

    function automatic pos_t clamp_len(input logic [NUMA_W-1:0] n);
        if (n > NUMA_W'(MAX_LEN))
            return POS_W'(MAX_LEN);
        return n[POS_W-1:0];
    endfunction

    // Lamps for slot p: shifting brings slot p's bit to the MSB of each column.
    function automatic lamp_t slot_lamps(input snap_t s, input pos_t p);
        code_t c1;
        code_t c2;
        code_t c3;
        code_t c4;
        lamp_t l;
        c1 = s.a1 << p;
        c2 = s.a2 << p;
        c3 = s.a3 << p;
        c4 = s.a4 << p;
        l[1] = c1[MAX_LEN-1];
        l[2] = c2[MAX_LEN-1];
        l[3] = c3[MAX_LEN-1];
        l[4] = c4[MAX_LEN-1];
        return l;
    endfunction

endpackage

// File: rtl/code_playback_if.sv
// Control, code snapshot inputs and lamp/status outputs of the playback block.
interface code_playback_if;
    import guess_pkg::*;

    logic                start;
    logic                abort;
    code_t               a1;
    code_t               a2;
    code_t               a3;
    code_t               a4;
    logic [NUMA_W-1:0]   numa;
    logic                led1;
    logic                led2;
    logic                led3;
    logic                led4;
    logic                busy;
    logic                done;
    pos_t                pos;
    logic                sym_valid;

    modport master (
        output start, abort, a1, a2, a3, a4, numa,
        input  led1, led2, led3, led4, busy, done, pos, sym_valid
    );

    modport slave (
        input  start, abort, a1, a2, a3, a4, numa,
        output led1, led2, led3, led4, busy, done, pos, sym_valid
    );

endinterface

// File: rtl/code_playback_phase_timer.sv
// Loadable count-down timer; stops at zero and flags it.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/code_playback.sv
// Replays a captured code as timed lamp pulses, one slot per ON/GAP period.
// Outputs are registered from next-state values so slot 0 lights on the cycle after start.
module code_playback
    import guess_pkg::*;
#(
    parameter int ON_CYCLES  = 3,
    parameter int OFF_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    code_playback_if.slave bus
);

    pb_state_t        state, next_state;
    pos_t             pos, next_pos;
    snap_t            snap, next_snap;
    pos_t             cap_len;
    logic             last_slot;

    logic             t_load;
    logic             t_zero;
    logic [CNT_W-1:0] t_val;

    lamp_t            led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             symv_q, symv_d;
    pos_t             pos_q, pos_d;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pos    <= '0;
            snap   <= '0;
            led_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            symv_q <= 1'b0;
            pos_q  <= '0;
        end else begin
            state  <= next_state;
            pos    <= next_pos;
            snap   <= next_snap;
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
            symv_q <= symv_d;
            pos_q  <= pos_d;
        end
    end

    always_comb begin
        next_state = state;
        next_pos   = pos;
        next_snap  = snap;
        cap_len    = clamp_len(bus.numa);
        last_slot  = ({1'b0, pos} + (POS_W+1)'(1)) >= {1'b0, snap.len};
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_snap  = '{a1: bus.a1, a2: bus.a2, a3: bus.a3, a4: bus.a4, len: cap_len};
                    next_pos   = '0;
                    next_state = (cap_len == '0) ? DONE : ON;
                end
            end
            ON: begin
                if (t_zero)
                    next_state = GAP;
            end
            GAP: begin
                if (t_zero) begin
                    if (last_slot) begin
                        next_state = DONE;
                    end else begin
                        next_state = ON;
                        next_pos   = pos + pos_t'(1);
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
                next_pos   = '0;
            end
            default: begin
                next_state = IDLE;
                next_pos   = '0;
            end
        endcase
        // Abort overrides everything, including a start seen in IDLE.
        if (bus.abort) begin
            next_state = IDLE;
            next_pos   = '0;
            next_snap  = snap;
        end
    end

    always_comb begin
        t_load = ((next_state == ON)  && (state != ON)) ||
                 ((next_state == GAP) && (state != GAP));
        t_val  = (next_state == ON) ? CNT_W'(ON_CYCLES - 1) : CNT_W'(OFF_CYCLES - 1);
        led_d  = (next_state == ON) ? slot_lamps(next_snap, next_pos) : '0;
        symv_d = (next_state == ON) && (state != ON);
        busy_d = (next_state == ON) || (next_state == GAP);
        done_d = (next_state == DONE);
        pos_d  = next_pos;
    end

    assign bus.led1      = led_q[1];
    assign bus.led2      = led_q[2];
    assign bus.led3      = led_q[3];
    assign bus.led4      = led_q[4];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sym_valid = symv_q;
    assign bus.pos       = pos_q;

endmodule

// File: tb/tb_code_playback.sv
// Bench for code_playback: per-cycle reference built from the slot timing formula.
module tb_code_playback;
    import guess_pkg::*;

    localparam int ONC  = 3;
    localparam int OFFC = 2;
    localparam int P    = ONC + OFFC;

    typedef struct packed {
        logic [3:0] leds;
        logic       busy;
        logic       done;
        logic       symv;
        logic [2:0] pos;
        logic       pos_chk;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   vectors = 0;
    int   errors = 0;

    code_t m_cols [4];
    int    m_len;

    code_playback_if bus();

    code_playback #(.ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // r counts cycles after the start edge within one replay period (total+2 long).
    function automatic exp_t model_at(input int r);
        exp_t  e;
        int    total;
        int    s;
        int    ph;
        code_t t;
        e = '0;
        e.pos_chk = 1'b1;
        total = m_len * P;
        if (r >= 1 && r <= total) begin
            s  = (r - 1) / P;
            ph = (r - 1) % P;
            e.busy = 1'b1;
            e.pos  = 3'(s);
            if (ph < ONC) begin
                for (int j = 0; j < 4; j++) begin
                    t = m_cols[j] >> (MAX_LEN - 1 - s);
                    e.leds[j] = t[0];
                end
                e.symv = (ph == 0);
            end
        end else if (r == total + 1) begin
            e.done    = 1'b1;
            e.pos_chk = 1'b0;
        end
        return e;
    endfunction

    task automatic play(input code_t c1, input code_t c2, input code_t c3, input code_t c4,
                        input logic [3:0] n, input int reps, input bit tamper, input string tag);
        int         total;
        exp_t       e;
        logic [3:0] obs;
        m_cols = '{c1, c2, c3, c4};
        m_len  = (n > 4'd7) ? 7 : int'(n);
        total  = m_len * P;
        @(negedge clk);
        bus.a1 = c1; bus.a2 = c2; bus.a3 = c3; bus.a4 = c4;
        bus.numa  = n;
        bus.start = 1'b1;
        for (int c = 1; c <= reps * (total + 2); c++) begin
            @(negedge clk);
            e   = model_at((c - 1) % (total + 2) + 1);
            obs = {bus.led4, bus.led3, bus.led2, bus.led1};
            vectors++;
            if (obs !== e.leds) begin
                errors++;
                $display("FAIL %s leds cycle %0d: got %b want %b", tag, c, obs, e.leds);
            end
            vectors++;
            if ({bus.busy, bus.done, bus.sym_valid} !== {e.busy, e.done, e.symv}) begin
                errors++;
                $display("FAIL %s busy/done/sym_valid cycle %0d: got %b want %b", tag, c,
                         {bus.busy, bus.done, bus.sym_valid}, {e.busy, e.done, e.symv});
            end
            if (e.pos_chk) begin
                vectors++;
                if (bus.pos !== e.pos) begin
                    errors++;
                    $display("FAIL %s pos cycle %0d: got %0d want %0d", tag, c, bus.pos, e.pos);
                end
            end
            if (tamper && c <= total) begin
                bus.a1 = code_t'($urandom); bus.a2 = code_t'($urandom);
                bus.a3 = code_t'($urandom); bus.a4 = code_t'($urandom);
                bus.numa  = 4'($urandom_range(0, 15));
                bus.start = 1'($urandom_range(0, 1));
            end else begin
                bus.start = (reps > 1) && (c < reps * (total + 2));
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.led4, bus.led3, bus.led2, bus.led1} !== 4'b0) begin
            errors++;
            $display("FAIL reset leds: got %b want 0000", {bus.led4, bus.led3, bus.led2, bus.led1});
        end
        vectors++;
        if ({bus.busy, bus.done, bus.sym_valid} !== 3'b0) begin
            errors++;
            $display("FAIL reset flags: got %b want 000", {bus.busy, bus.done, bus.sym_valid});
        end
        vectors++;
        if (bus.pos !== 3'd0) begin
            errors++;
            $display("FAIL reset pos: got %0d want 0", bus.pos);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_code_1234;
        play(7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 4'd4, 1, 1'b0, "code1234");
    endtask

    task automatic test_len_zero;
        play(7'h55, 7'h2A, 7'h7F, 7'h01, 4'd0, 1, 1'b0, "len0");
    endtask

    task automatic test_clamp;
        play(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'd9, 1, 1'b0, "clamp9");
    endtask

    task automatic test_multi_bit;
        play(7'b0100000, 7'b0, 7'b0100000, 7'b0, 4'd3, 1, 1'b0, "multibit");
    endtask

    task automatic test_ignore_inputs;
        play(code_t'($urandom), code_t'($urandom), code_t'($urandom), code_t'($urandom),
             4'($urandom_range(1, 7)), 1, 1'b1, "ignore");
    endtask

    task automatic test_back_to_back;
        play(code_t'($urandom), code_t'($urandom), code_t'($urandom), code_t'($urandom),
             4'd2, 3, 1'b0, "b2b");
        play(7'h0, 7'h0, 7'h0, 7'h0, 4'd0, 3, 1'b0, "b2b_len0");
    endtask

    task automatic test_abort;
        exp_t       e;
        logic [3:0] obs;
        m_cols = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000};
        m_len  = 4;
        @(negedge clk);
        bus.a1 = m_cols[0]; bus.a2 = m_cols[1]; bus.a3 = m_cols[2]; bus.a4 = m_cols[3];
        bus.numa  = 4'd4;
        bus.start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c <= 9) begin
                e = model_at(c);
            end else begin
                e = '0;
                e.pos_chk = 1'b1;
            end
            obs = {bus.led4, bus.led3, bus.led2, bus.led1};
            vectors++;
            if (obs !== e.leds) begin
                errors++;
                $display("FAIL abort leds cycle %0d: got %b want %b", c, obs, e.leds);
            end
            vectors++;
            if ({bus.busy, bus.done, bus.sym_valid} !== {e.busy, e.done, e.symv}) begin
                errors++;
                $display("FAIL abort busy/done/sym_valid cycle %0d: got %b want %b", c,
                         {bus.busy, bus.done, bus.sym_valid}, {e.busy, e.done, e.symv});
            end
            vectors++;
            if (bus.pos !== e.pos) begin
                errors++;
                $display("FAIL abort pos cycle %0d: got %0d want %0d", c, bus.pos, e.pos);
            end
            bus.abort = (c == 9);
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.a1 = 7'h7F; bus.a2 = 7'h00; bus.a3 = 7'h7F; bus.a4 = 7'h00;
        bus.numa  = 4'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.led3, bus.led1} !== 3'b111) begin
            errors++;
            $display("FAIL rstmid pre-reset busy/led3/led1: got %b want 111", {bus.busy, bus.led3, bus.led1});
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.led4, bus.led3, bus.led2, bus.led1, bus.busy, bus.done, bus.sym_valid} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid outputs: got %b want 0000000",
                     {bus.led4, bus.led3, bus.led2, bus.led1, bus.busy, bus.done, bus.sym_valid});
        end
        vectors++;
        if (bus.pos !== 3'd0) begin
            errors++;
            $display("FAIL rstmid pos: got %0d want 0", bus.pos);
        end
        @(negedge clk);
        reset_n = 1'b1;
        play(7'b0010000, 7'b1000000, 7'b0000001, 7'b0100000, 4'd3, 1, 1'b0, "after_rst");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            play(code_t'($urandom), code_t'($urandom), code_t'($urandom), code_t'($urandom),
                 4'($urandom_range(0, 15)), 1, 1'b0, "random");
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.a1 = '0; bus.a2 = '0; bus.a3 = '0; bus.a4 = '0;
        bus.numa = '0;
        test_reset;
        test_code_1234;
        test_len_zero;
        test_clamp;
        test_multi_bit;
        test_ignore_inputs;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
